// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment driver: one-cold active-low anode scan,
// per-slot blanking guard, and frame-aligned double buffering of segment data.
module display_scanner #(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 8,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNT_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [DIGITS*SEG_W-1:0]   seg_data,
  input  logic [DIGITS-1:0]         digit_en,
  output logic [DIGITS-1:0]         an,
  output logic [SEG_W-1:0]          seg_n,
  output logic [IDX_W-1:0]          digit_idx,
  output logic                      frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  // One bit wider than cnt so a guard of any legal length compares cleanly.
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [DIGITS*SEG_W-1:0] shadow;
  logic [DIGITS*SEG_W-1:0] pending;
  logic                    pend_v;

  phase_t                  phase;
  logic                    slot_end;
  logic                    frame_end;
  logic [SEG_W-1:0]        cur_seg;
  logic                    cur_en;
  logic [DIGITS-1:0]       an_sel;
  logic [DIGITS-1:0]       an_next;
  logic [SEG_W-1:0]        seg_next;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = enable && slot_end && (idx == IDX_LAST);
    phase     = ({1'b0, cnt} < BLANK_END) ? PH_BLANK : PH_DRIVE;

    cur_seg = '0;
    cur_en  = 1'b0;
    an_sel  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_seg   = shadow[i*SEG_W +: SEG_W];
        cur_en    = digit_en[i];
        an_sel[i] = 1'b0;
      end
    end

    an_next  = '1;
    seg_next = '1;
    if (enable && (phase == PH_DRIVE) && cur_en) begin
      an_next  = an_sel;
      seg_next = ~cur_seg;
    end
  end

  // Scan position: a disabled scanner parks at digit 0, cycle 0, so that
  // re-enabling always begins with a blanking guard.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Double buffer: data lands in pending mid-frame and is promoted only at
  // the frame boundary; a load coinciding with that boundary bypasses pending.
  // NOTE: these wide data registers are reset on purpose, because a reset
  // must both blank the display content and discard any queued frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        shadow <= seg_data;
      end else if (pend_v) begin
        shadow <= pending;
      end
      pend_v <= 1'b0;
    end else if (load) begin
      pending <= seg_data;
      pend_v  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      seg_n      <= '1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg_n      <= seg_next;
      digit_idx  <= idx;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a slot/frame-time reference model
// for the 4-digit configuration plus fixed checks on a 3-digit, no-guard build.
module tb_display_scanner;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [31:0] seg_data;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [7:0]  seg_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  logic        reset_b, enable_b, load_b;
  logic [23:0] seg_data_b;
  logic [2:0]  digit_en_b;
  logic [2:0]  an_b;
  logic [7:0]  seg_n_b;
  logic [1:0]  digit_idx_b;
  logic        frame_tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_scanner #(.DIGITS(D), .SEG_W(8), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seg_data(seg_data),
    .digit_en(digit_en), .an(an), .seg_n(seg_n), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  display_scanner #(.DIGITS(3), .SEG_W(8), .PRESCALE(4), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .load(load_b), .seg_data(seg_data_b),
    .digit_en(digit_en_b), .an(an_b), .seg_n(seg_n_b), .digit_idx(digit_idx_b),
    .frame_tick(frame_tick_b)
  );

  // Reference model: t counts enabled cycles since the scan (re)started.
  int          t;
  logic [31:0] shown_w;
  logic [31:0] pend_w;
  bit          pend_v_m;
  int          pre_d;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic [1:0]  exp_idx;
  logic        exp_tick;

  task automatic step();
    int  pos, d, o;
    bit  fe;
    fe = 1'b0;
    d  = 0;
    if (reset) begin
      exp_an = '1; exp_seg = '1; exp_idx = '0; exp_tick = 1'b0;
      t = 0; shown_w = '0; pend_v_m = 1'b0;
    end else begin
      pos = t % FRAME;
      d   = pos / P;
      o   = pos % P;
      exp_idx = 2'(d);
      exp_an = '1; exp_seg = '1; exp_tick = 1'b0;
      if (enable) begin
        fe = (d == D - 1) && (o == P - 1);
        exp_tick = fe;
        if (o >= B && digit_en[d]) begin
          exp_an  = ~(4'b0001 << d);
          exp_seg = ~shown_w[d*8 +: 8];
        end
        t = t + 1;
      end else begin
        t = 0;
      end
      if (fe) begin
        if (load) shown_w = seg_data;
        else if (pend_v_m) shown_w = pend_w;
        pend_v_m = 1'b0;
      end else if (load) begin
        pend_w   = seg_data;
        pend_v_m = 1'b1;
      end
    end
    pre_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int phase);
    while (t % FRAME != phase) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; load = 1'b0; seg_data = '0; digit_en = 4'b1111;
    reset_b = 1'b1; enable_b = 1'b1; load_b = 1'b0; seg_data_b = '0; digit_en_b = 3'b111;
    step(); step();
    checks++;
    if ({an, seg_n, digit_idx, frame_tick} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got an=%b seg=%h idx=%0d tick=%b want an=1111 seg=ff idx=0 tick=0",
               an, seg_n, digit_idx, frame_tick);
    end
  endtask

  task automatic test_first_frame();
    reset = 1'b0; load = 1'b1; seg_data = 32'h3F06_5B4F;
    for (int e = 1; e <= 64; e++) begin
      step();
      load = 1'b0;
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL first_frame_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (e <= 32) begin
        checks++;
        if (seg_n !== 8'hFF) begin
          errors++; $display("FAIL first_frame_blank e=%0d: seg_n got %h want ff", e, seg_n);
        end
      end
      if (e == 32) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++; $display("FAIL first_frame_tick: got %b want 1", frame_tick);
        end
      end
      if (e == 35) begin
        checks++;
        if ({an, seg_n} !== {4'b1110, 8'hB0}) begin
          errors++; $display("FAIL digit0_shown: got an=%b seg=%h want an=1110 seg=b0", an, seg_n);
        end
      end
      if (e == 59) begin
        checks++;
        if ({an, seg_n} !== {4'b0111, 8'hC0}) begin
          errors++; $display("FAIL digit3_shown: got an=%b seg=%h want an=0111 seg=c0", an, seg_n);
        end
      end
    end
  endtask

  task automatic test_free_run();
    int ticks = 0;
    int last_tick = -1;
    int blank_run = 0;
    for (int e = 0; e < 3 * FRAME; e++) begin
      step();
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL free_run_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL one_cold e=%0d: an got %b want at most one 0", e, an);
      end
      blank_run = (an === 4'hF) ? blank_run + 1 : 0;
      checks++;
      if (blank_run > B) begin
        errors++; $display("FAIL blank_len e=%0d: blank run got %0d want <= %0d", e, blank_run, B);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (e - last_tick != FRAME) begin
            errors++; $display("FAIL tick_period: got %0d want %0d", e - last_tick, FRAME);
          end
        end
        last_tick = e;
        ticks++;
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++; $display("FAIL tick_count: got %0d want 3", ticks);
    end
  endtask

  task automatic test_last_write_wins();
    align(0);
    for (int e = 0; e < 2 * FRAME; e++) begin
      load = 1'b0;
      if (e == 5) begin load = 1'b1; seg_data = 32'h0101_0101; end
      if (e == 7) begin load = 1'b1; seg_data = 32'h0202_0202; end
      step();
      load = 1'b0;
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL buffer_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      checks++;
      if (e < FRAME && (seg_n === 8'hFE || seg_n === 8'hFD)) begin
        errors++; $display("FAIL no_tear e=%0d: seg_n got %h want old frame data", e, seg_n);
      end else if (e >= FRAME && an !== 4'hF && seg_n !== 8'hFD) begin
        errors++; $display("FAIL last_write e=%0d: seg_n got %h want fd", e, seg_n);
      end
    end
  endtask

  task automatic test_digit_mask();
    align(0);
    digit_en = 4'b1011;
    for (int e = 0; e < FRAME; e++) begin
      step();
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL mask_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (pre_d == 2) begin
        checks++;
        if ({an, seg_n} !== {4'hF, 8'hFF}) begin
          errors++; $display("FAIL masked_slot e=%0d: got an=%b seg=%h want an=1111 seg=ff", e, an, seg_n);
        end
      end
    end
    digit_en = 4'b1111;
  endtask

  task automatic test_enable_drop();
    align(2 * P + 4);
    enable = 1'b0;
    for (int e = 0; e < 5; e++) begin
      load = (e == 1);
      seg_data = 32'h1122_3344;
      step();
      load = 1'b0;
      checks++;
      if ({an, seg_n, frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
        errors++; $display("FAIL disabled_blank e=%0d: got an=%b seg=%h tick=%b want 1111 ff 0",
                           e, an, seg_n, frame_tick);
      end
    end
    enable = 1'b1;
    for (int e = 1; e <= 2 * FRAME; e++) begin
      step();
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL restart_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (e <= 3) begin
        checks++;
        if (an !== ((e == 3) ? 4'b1110 : 4'b1111)) begin
          errors++; $display("FAIL restart_seq e=%0d: an got %b want %b", e, an,
                             (e == 3) ? 4'b1110 : 4'b1111);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    align(10);
    load = 1'b1; seg_data = 32'h5566_7788;
    step();
    load = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({an, seg_n, digit_idx, frame_tick} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_frame: got an=%b seg=%h idx=%0d tick=%b want 1111 ff 0 0",
                         an, seg_n, digit_idx, frame_tick);
    end
    reset = 1'b0;
    for (int e = 0; e < FRAME + 8; e++) begin
      step();
      checks++;
      if (seg_n !== 8'hFF || an !== exp_an) begin
        errors++; $display("FAIL pending_discard e=%0d: got an=%b seg=%h want an=%b seg=ff",
                           e, an, seg_n, exp_an);
      end
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 400; e++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 15) != 0);
      load     = ($urandom_range(0, 9) == 0);
      seg_data = $urandom;
      if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
      step();
      checks++;
      if ({an, seg_n, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("FAIL random_model e=%0d: got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 e, an, seg_n, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL random_one_cold e=%0d: an got %b want at most one 0", e, an);
      end
    end
    reset = 1'b0; enable = 1'b1; load = 1'b0; digit_en = 4'b1111;
  endtask

  task automatic test_small_config();
    int          d;
    logic [2:0]  want_an;
    reset_b = 1'b1;
    step();
    reset_b = 1'b0; load_b = 1'b1; seg_data_b = 24'hAB_CD_EF;
    for (int k = 1; k <= 16; k++) begin
      step();
      load_b = 1'b0;
      d = ((k - 1) / 4) % 3;
      want_an = ~(3'b001 << d);
      checks++;
      if ({an_b, digit_idx_b} !== {want_an, 2'(d)}) begin
        errors++; $display("FAIL small_scan k=%0d: got an=%b idx=%0d want an=%b idx=%0d",
                           k, an_b, digit_idx_b, want_an, d);
      end
      checks++;
      if (frame_tick_b !== (k == 12)) begin
        errors++; $display("FAIL small_tick k=%0d: got %b want %b", k, frame_tick_b, k == 12);
      end
      checks++;
      if (seg_n_b !== ((k > 12) ? ~seg_data_b[d*8 +: 8] : 8'hFF)) begin
        errors++; $display("FAIL small_seg k=%0d: got %h want %h", k, seg_n_b,
                           (k > 12) ? ~seg_data_b[d*8 +: 8] : 8'hFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_free_run();
    test_last_write_wins();
    test_digit_mask();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Parametrised, time-multiplexed driver for common-anode 7-segment displays. It generalises the fixed 2-to-4 one-cold digit decoder: it owns its own scan counter and rotates a one-cold, active-low anode select across `DIGITS` positions. It inserts a blanking guard between digits to suppress ghosting, and it double-buffers segment data so a new frame never tears mid-scan. It sits between the score and game logic and the board display pins.

## Interface
Parameters:
- `DIGITS`, default 4: number of multiplexed digits; must be at least 2.
- `SEG_W`, default 8: segment bits per digit (a–g plus dp).
- `PRESCALE`, default 50000: clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot during which all outputs are off; may be 0.
- `IDX_W` (local): max(1, clog2(`DIGITS`)). `CNT_W` (local): max(1, clog2(`PRESCALE`)).

Ports:
- `clk`, in, 1: the single clock. Everything is posedge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: scan enable. When low, outputs are blanked and the scan is held at digit 0, cycle 0.
- `load`, in, 1: one-cycle request to capture `seg_data`.
- `seg_data`, in, `DIGITS*SEG_W`: active-high segments. Digit i is held in bits [i*SEG_W +: SEG_W].
- `digit_en`, in, `DIGITS`: per-digit enable mask. A 0 bit blanks that digit's slot. The mask is sampled live, not buffered.
- `an`, out, `DIGITS`: one-cold active-low anodes, registered.
- `seg_n`, out, `SEG_W`: active-low segments, registered.
- `digit_idx`, out, `IDX_W`: index of the slot currently shown, registered.
- `frame_tick`, out, 1: one-cycle pulse marking the end of a full frame, registered.

## Operation
- Internal registers:
  - `cnt` runs 0..`PRESCALE`-1.
  - `idx` runs 0..`DIGITS`-1.
  - `shadow` holds `DIGITS*SEG_W` bits of displayed data.
  - `pending` holds `DIGITS*SEG_W` bits plus a `pend_v` valid flag.
- Scan, when `enable` is 1:
  - `cnt` increments every cycle.
  - When `cnt` is `PRESCALE`-1, `cnt` returns to 0 and `idx` increments.
  - `idx` wraps from `DIGITS`-1 to 0.
- Slot phases, decoded from `cnt`:
  - BLANK phase: `cnt` < `BLANK_CYCLES`. `an` is all ones and `seg_n` is all ones.
  - DRIVE phase: `cnt` ≥ `BLANK_CYCLES`.
    - If `digit_en[idx]` is 1: `an` is all ones except bit `idx`, which is 0, and `seg_n` is ~`shadow[idx]`.
    - If `digit_en[idx]` is 0: `an` and `seg_n` are both all ones.
  - In every phase, `an` has at most one 0 bit.
- Frame end: the edge at which `cnt` is `PRESCALE`-1 and `idx` is `DIGITS`-1.
- Buffering:
  - `load` on a non-frame-end edge writes `seg_data` into `pending` and sets `pend_v`. A later `load` overwrites `pending`; the last write wins.
  - On the frame-end edge, `shadow` is updated as follows:
    - If `load` is 1, `shadow` takes `seg_data` directly.
    - Otherwise, if `pend_v` is 1, `shadow` takes `pending`.
    - In both cases `pend_v` is cleared. Otherwise `shadow` is unchanged.
  - New data therefore always first appears in digit 0's slot.
- `enable` low:
  - `cnt` and `idx` are forced to 0.
  - `an`, `seg_n` and `frame_tick` are inactive (ones, ones and 0 respectively).
  - `load` still updates `pending`.
  - With `cnt` held at 0, no frame-end edge occurs, so `shadow` does not update.
  - When `enable` returns to 1, the scan restarts at digit 0 in its BLANK phase.
- Reset:
  - `cnt`, `idx`, `shadow`, `pending` and `pend_v` are 0.
  - `an` and `seg_n` are all ones; `digit_idx` and `frame_tick` are 0.
  - Reset overrides `enable` and `load`.
  - Reset asserted mid-slot or mid-frame aborts the scan immediately and discards `pending`.

## Timing
- Outputs are registered. The values after edge n are decoded from `cnt`, `idx`, `shadow` and `digit_en` as they were just before edge n, giving 1 cycle of latency.
- `digit_idx` follows `idx` with the same 1-cycle delay, aligned with `an`.
- `frame_tick` is 1 for exactly one cycle, immediately after the frame-end edge. The frame period is `DIGITS*PRESCALE` cycles.
- Each digit is lit for `PRESCALE-BLANK_CYCLES` cycles per frame.
- When `load` is 1 on the frame-end edge, `seg_data` reaches `shadow` at that edge. It is first driven on `seg_n` after edge `BLANK_CYCLES`+1 of the next frame (edges counted from the frame-end edge).

## Test plan
Cases 1–4 use `DIGITS`=4, `PRESCALE`=8, `BLANK_CYCLES`=2, `SEG_W`=8. `enable`=1 and `digit_en`=4'b1111 unless stated.

1. Release reset, then `load` with `seg_data`=32'h3F06_5B4F (digit 3 is 3F, digit 0 is 4F).
   - Outputs are blank through the first frame and `frame_tick` is high after edge 32.
   - In frame 2, after its 3rd edge, `an`=4'b1110 and `seg_n`=8'hB0.
   - Digit 3 later shows `an`=4'b0111 and `seg_n`=8'hC0.
2. Free run for 3 frames.
   - `frame_tick` pulses every 32 cycles.
   - `an` is never 0 in more than one bit, and is all ones for exactly 2 cycles at every slot start.
3. Load A=32'h0101_0101 mid-frame, then load B=32'h0202_0202 two cycles later, in the same frame.
   - The current frame is unchanged.
   - The next frame shows B and never shows A.
4. Set `digit_en`=4'b1011.
   - In slot 2, `an`=4'b1111 and `seg_n`=8'hFF.
   - The other digits scan normally.
5. Use `DIGITS`=3, `PRESCALE`=4, `BLANK_CYCLES`=0.
   - `an` cycles 110 → 101 → 011, each for 4 cycles, with no blank cycles.
   - `digit_idx` goes 0, 1, 2, 0.
6. Drop `enable` mid-slot at digit 2, hold it low for 5 cycles, then raise it.
   - Outputs are blank, and `frame_tick` stays 0, after the edges that sample `enable`=0.
   - The scan restarts at digit 0, showing BLANK for 2 cycles, then `an`=4'b1110.
   - Asserting `reset` mid-frame gives all outputs at their reset values after the next edge, and `pend_v` is cleared.
